// File: rtl/spi_master_multi.sv
// Parametrised SPI master: configurable word width, chip-select count and clock
// divider, with CPOL/CPHA mode and bit order latched per transfer.
module spi_master_multi #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CS     = 1,
  parameter int DIV_WIDTH  = 8,
  localparam int CsW       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic [CsW-1:0]        cs_sel,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsb_first,
  input  logic [DIV_WIDTH-1:0]  clk_div,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic [NUM_CS-1:0]     cs_b,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int EdgeW = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [EdgeW-1:0] LastEdge = EdgeW'(2 * DATA_WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StLead, StXfer, StTrail, StEnd} state_t;

  state_t                state_q, state_d;
  logic [DIV_WIDTH:0]    cnt_q, cnt_d;
  logic [EdgeW-1:0]      edge_cnt_q, edge_cnt_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic                  cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
  logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, rx_data_q, rx_data_d;
  logic                  sclk_q, sclk_d, mosi_q, mosi_d, busy_q, busy_d, done_q, done_d;
  logic [NUM_CS-1:0]     cs_b_q, cs_b_d, cs_dec;
  logic                  cnt_hit, leading, last_edge;

  function automatic logic [DATA_WIDTH-1:0] tx_shift(input logic [DATA_WIDTH-1:0] v,
                                                     input logic lsb);
    return lsb ? {1'b0, v[DATA_WIDTH-1:1]} : {v[DATA_WIDTH-2:0], 1'b0};
  endfunction

  function automatic logic tx_bit(input logic [DATA_WIDTH-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_WIDTH-1];
  endfunction

  // Chip-select decode; out-of-range selects leave every line deasserted.
  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (cs_sel == CsW'(i)) cs_dec[i] = 1'b0;
    end
  end

  assign cnt_hit   = (cnt_q == {1'b0, div_q});
  assign leading   = ~edge_cnt_q[0];
  assign last_edge = (edge_cnt_q == LastEdge);

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    edge_cnt_d = edge_cnt_q;
    div_d      = div_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    lsb_d      = lsb_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_b_d     = cs_b_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        sclk_d = cpol;
        mosi_d = 1'b0;
        if (start) begin
          state_d    = StLead;
          cnt_d      = '0;
          edge_cnt_d = '0;
          div_d      = clk_div;
          cpol_d     = cpol;
          cpha_d     = cpha;
          lsb_d      = lsb_first;
          rx_sr_d    = '0;
          busy_d     = 1'b1;
          cs_b_d     = cs_dec;
          if (!cpha) begin
            // Mode with cpha=0 presents the first bit before the first edge.
            mosi_d  = tx_bit(tx_data, lsb_first);
            tx_sr_d = tx_shift(tx_data, lsb_first);
          end else begin
            tx_sr_d = tx_data;
          end
        end
      end
      StLead, StXfer: begin
        if (cnt_hit) begin
          cnt_d      = '0;
          edge_cnt_d = edge_cnt_q + 1'b1;
          sclk_d     = ~sclk_q;
          if (leading ^ cpha_q) begin
            rx_sr_d = lsb_q ? {miso, rx_sr_q[DATA_WIDTH-1:1]} : {rx_sr_q[DATA_WIDTH-2:0], miso};
          end
          if (cpha_q ? leading : (!leading && !last_edge)) begin
            mosi_d  = tx_bit(tx_sr_q, lsb_q);
            tx_sr_d = tx_shift(tx_sr_q, lsb_q);
          end
          state_d = last_edge ? StTrail : StXfer;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StTrail: begin
        if (cnt_hit) begin
          state_d   = StEnd;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          cs_b_d    = '1;
          mosi_d    = 1'b0;
          rx_data_d = rx_sr_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StEnd: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      edge_cnt_q <= '0;
      div_q      <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_b_q     <= '1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      edge_cnt_q <= edge_cnt_d;
      div_q      <= div_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      lsb_q      <= lsb_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_b_q     <= cs_b_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign cs_b    = cs_b_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi: a vector table for whole transfers plus
// hand-written sequences for start spamming, mid-transfer reset and a slow divider.
module tb_spi_master_multi;

  logic       clk = 1'b0;
  logic       rst, start, cpol, cpha, lsb_first, miso;
  logic [7:0] tx_data, rx_data, clk_div;
  logic [2:0] cs_sel;
  logic [4:0] cs_b;
  logic       busy, done, sclk, mosi;
  logic       loop_en, miso_s;

  logic       s_start, s_busy, s_done, s_sclk, s_mosi;
  logic [0:0] s_csb;
  logic [3:0] s_rx;

  always #5 clk = ~clk;

  assign miso = loop_en ? mosi : miso_s;

  spi_master_multi #(.DATA_WIDTH(8), .NUM_CS(5), .DIV_WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .cs_sel(cs_sel),
    .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .clk_div(clk_div),
    .busy(busy), .done(done), .rx_data(rx_data), .cs_b(cs_b), .sclk(sclk),
    .mosi(mosi), .miso(miso)
  );

  spi_master_multi #(.DATA_WIDTH(4), .NUM_CS(1), .DIV_WIDTH(8)) u_dut4 (
    .clk(clk), .rst(rst), .start(s_start), .tx_data(4'hB), .cs_sel(1'b0),
    .cpol(1'b0), .cpha(1'b0), .lsb_first(1'b0), .clk_div(8'hFF),
    .busy(s_busy), .done(s_done), .rx_data(s_rx), .cs_b(s_csb), .sclk(s_sclk),
    .mosi(s_mosi), .miso(s_mosi)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [2:0] cs;
    logic       pol, pha, lsb;
    logic [7:0] div;
    logic       lp;
    logic [7:0] sw;
    logic [7:0] exp_rx;
    int         exp_done;
    int         exp_edge1;
    logic [4:0] exp_mask;
    logic [7:0] exp_mosi;
  } vec_t;

  vec_t vecs[6];

  // Results of the last run_xfer.
  int         done_rel, done_cnt, edges, first_edge, cs_first, overlap;
  logic [4:0] cs_mask;
  logic [7:0] mosi_seq, rx_cap;

  task automatic run_xfer(input vec_t v, input bit spam);
    int t0, rel, limit, sbit;
    logic prev;
    @(negedge clk);
    start = 1'b0; tx_data = v.tx; cs_sel = v.cs; cpol = v.pol; cpha = v.pha;
    lsb_first = v.lsb; clk_div = v.div; loop_en = v.lp; miso_s = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("idle_sclk", int'(sclk), int'(v.pol));
    sbit = 0;
    if (!v.lp && !v.pha) begin
      miso_s = v.sw[7];
      sbit = 1;
    end
    done_rel = -1; done_cnt = 0; edges = 0; first_edge = -1; cs_first = -1;
    overlap = 0; cs_mask = '0; mosi_seq = '0; rx_cap = '0;
    limit = 1 + 17 * (int'(v.div) + 1) + 4;
    start = 1'b1;
    t0 = cyc;
    prev = sclk;
    do begin
      @(negedge clk);
      rel = cyc - t0;
      if (!spam) begin
        start = 1'b0;
        // Config inputs wander while busy; the latched copy must rule.
        tx_data = 8'($urandom); cs_sel = 3'($urandom); cpol = 1'($urandom);
        cpha = 1'($urandom); lsb_first = 1'($urandom); clk_div = 8'($urandom);
      end
      if (sclk != prev) begin
        edges++;
        if (edges == 1) first_edge = rel;
        if (v.pha ? (edges % 2 == 0) : (edges % 2 == 1)) mosi_seq = {mosi_seq[6:0], mosi};
        if (!v.lp && sbit < 8 &&
            ((v.pha && edges % 2 == 1) || (!v.pha && edges % 2 == 0 && edges < 16))) begin
          miso_s = v.sw[7-sbit];
          sbit++;
        end
      end
      prev = sclk;
      cs_mask = cs_mask | ~cs_b;
      if (cs_b != 5'h1F && cs_first < 0) cs_first = rel;
      if (busy && done) overlap++;
      if (done) begin
        done_cnt++;
        if (done_rel < 0) begin
          done_rel = rel;
          rx_cap = rx_data;
        end
      end
    end while (done_rel < 0 && rel < limit);
    if (!spam) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (done) done_cnt++;
      end
      check("rx_hold", int'(rx_data), int'(rx_cap));
    end
  endtask

  initial begin
    int t0, rel, e1, e2, dn, nd;
    logic prev;
    vecs[0] = '{8'hA5, 3'd0, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 8'h00, 8'hA5, 35, 3, 5'b00001, 8'hA5};
    vecs[1] = '{8'h3C, 3'd0, 1'b1, 1'b1, 1'b1, 8'd1, 1'b0, 8'h96, 8'h69, 35, 3, 5'b00001, 8'h3C};
    vecs[2] = '{8'h5A, 3'd2, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'h00, 8'h5A, 18, 2, 5'b00100, 8'h5A};
    vecs[3] = '{8'hC3, 3'd5, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'h00, 8'hC3, 18, 2, 5'b00000, 8'hC3};
    vecs[4] = '{8'h81, 3'd1, 1'b0, 1'b1, 1'b0, 8'd2, 1'b1, 8'h00, 8'h81, 52, 4, 5'b00010, 8'h81};
    vecs[5] = '{8'h17, 3'd3, 1'b1, 1'b0, 1'b1, 8'd3, 1'b1, 8'h00, 8'h17, 69, 5, 5'b01000, 8'hE8};

    rst = 1'b1; start = 1'b0; s_start = 1'b0; tx_data = '0; cs_sel = '0; cpol = 1'b0;
    cpha = 1'b0; lsb_first = 1'b0; clk_div = '0; loop_en = 1'b1; miso_s = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_rx", int'(rx_data), 0);
    check("rst_cs_b", int'(cs_b), 'h1F);
    check("rst_sclk", int'(sclk), 0);
    check("rst_mosi", int'(mosi), 0);
    check("rst_busy4", int'(s_busy), 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_xfer(vecs[i], 1'b0);
      check($sformatf("v%0d_done_cycle", i), done_rel, vecs[i].exp_done);
      check($sformatf("v%0d_rx", i), int'(rx_cap), int'(vecs[i].exp_rx));
      check($sformatf("v%0d_first_edge", i), first_edge, vecs[i].exp_edge1);
      check($sformatf("v%0d_edges", i), edges, 16);
      check($sformatf("v%0d_cs_mask", i), int'(cs_mask), int'(vecs[i].exp_mask));
      check($sformatf("v%0d_mosi_bits", i), int'(mosi_seq), int'(vecs[i].exp_mosi));
      check($sformatf("v%0d_done_count", i), done_cnt, 1);
      check($sformatf("v%0d_busy_done_overlap", i), overlap, 0);
      if (vecs[i].exp_mask != 5'b0) check($sformatf("v%0d_cs_first", i), cs_first, 1);
    end

    // start held high throughout: one done, then restart the cycle after done.
    run_xfer(vecs[0], 1'b1);
    check("spam_done_cycle", done_rel, 35);
    check("spam_done_count", done_cnt, 1);
    check("spam_rx", int'(rx_cap), 'hA5);
    @(negedge clk);
    check("spam_after_done_busy", int'(busy), 0);
    @(negedge clk);
    start = 1'b0;
    check("spam_restart_busy", int'(busy), 1);
    check("spam_restart_cs", int'(cs_b[0]), 0);
    dn = -1; nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (dn < 0) dn = i + 1;
      end
    end
    check("spam_second_done_offset", dn, 34);
    check("spam_second_done_count", nd, 1);

    // Reset at sclk edge 5 of a mode-0 transfer.
    @(negedge clk);
    tx_data = 8'hA5; cs_sel = 3'd0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    clk_div = 8'd1; loop_en = 1'b1;
    start = 1'b1; t0 = cyc; prev = sclk; e1 = 0; rel = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      rel = cyc - t0;
      if (sclk != prev) e1++;
      prev = sclk;
    end while (e1 < 5 && rel < 40);
    check("rst_at_edge5_cycle", rel, 11);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_cs_b", int'(cs_b), 'h1F);
    check("midrst_busy", int'(busy), 0);
    check("midrst_sclk", int'(sclk), 0);
    check("midrst_done", int'(done), 0);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("midrst_no_done", nd, 0);
    run_xfer(vecs[0], 1'b0);
    check("postrst_done_cycle", done_rel, 35);
    check("postrst_rx", int'(rx_cap), 'hA5);

    // W=4, all-ones divider on the second instance.
    @(negedge clk);
    s_start = 1'b1; t0 = cyc; prev = s_sclk; e1 = -1; e2 = -1; dn = -1; nd = 0; rel = 0;
    do begin
      @(negedge clk);
      s_start = 1'b0;
      rel = cyc - t0;
      if (s_sclk != prev) begin
        nd++;
        if (nd == 1) e1 = rel;
        if (nd == 2) e2 = rel;
      end
      prev = s_sclk;
      if (s_done && dn < 0) dn = rel;
    end while (dn < 0 && rel < 2400);
    check("div255_first_edge", e1, 257);
    check("div255_second_edge", e2, 513);
    check("div255_edges", nd, 8);
    check("div255_done_cycle", dn, 2305);
    check("div255_rx", int'(s_rx), 'hB);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
